sram_word_controller: RTL

- Downstream stage of the 2-way data cache controller.
- Converts single 32-bit word read/write requests, issued on a cache miss or write-through, into two sequential 16-bit accesses on the board SRAM (low half first, then high half).
- Holds `ready` low for the whole transaction and pulses it high for one cycle when the word is complete.
- `ready` is high while idle, so the cache's freeze logic does not stall when no request is pending.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_word_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared constants and FSM encodings for the 32-bit-word to 16-bit SRAM controller.
package sram_pkg;

  localparam int SRAM_DATA_W      = 16;
  localparam int SRAM_ADDR_W      = 18;
  localparam int DATA_MEM_BASE    = 1024;
  localparam int WORD_OFFSET_BITS = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD_LO = 3'd1;
  localparam state_t ST_RD_HI = 3'd2;
  localparam state_t ST_WR_LO = 3'd3;
  localparam state_t ST_WR_HI = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/sram_word_controller.sv
// Splits 32-bit word reads/writes into two timed 16-bit SRAM accesses (low half first).
// Optional build macro SRAM_BASE_OFFSET_EN rebases byte address DATA_MEM_BASE to SRAM half-word 0.
module sram_word_controller
  import sram_pkg::*;
#(
  parameter int CYCLES_PER_HALF = 3,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [DATA_W-1:0]      writeData,
  output logic [DATA_W-1:0]      readData,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0]      SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  localparam int CNT_W = 4;

`ifdef SRAM_BASE_OFFSET_EN
  localparam logic [31:0] ADDR_BIAS = 32'(DATA_MEM_BASE);
`else
  localparam logic [31:0] ADDR_BIAS = 32'd0;
`endif

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic [ADDR_W-2:0]        lat_addr;
  logic [DATA_W-1:0]        lat_data;
  logic [SRAM_DATA_W-1:0]   rd_lo;
  logic                     last;
  logic [31:0]              addr_biased;
  logic                     unused_addr_bits;

  logic                     half_sel;
  logic                     active;
  logic                     drive;
  logic                     we_n;
  logic                     oe_n;
  logic [SRAM_DATA_W-1:0]   wdata_half;

  assign addr_biased      = address - ADDR_BIAS;
  assign unused_addr_bits = ^{addr_biased[31:ADDR_W+1], addr_biased[WORD_OFFSET_BITS-1:0]};
  assign last             = (count == CNT_W'(CYCLES_PER_HALF - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      rd_lo    <= '0;
      readData <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (wr_en) begin
            lat_addr <= addr_biased[ADDR_W:WORD_OFFSET_BITS];
            lat_data <= writeData;
            state    <= ST_WR_LO;
          end else if (rd_en) begin
            lat_addr <= addr_biased[ADDR_W:WORD_OFFSET_BITS];
            state    <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (last) begin
            rd_lo <= SRAM_DQ;
            state <= ST_RD_HI;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        // readData updates only once both halves are in, so an aborted read leaves it intact.
        ST_RD_HI: begin
          if (last) begin
            readData <= {SRAM_DQ, rd_lo};
            state    <= ST_DONE;
            count    <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_WR_LO: begin
          if (last) begin
            state <= ST_WR_HI;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_WR_HI: begin
          if (last) begin
            state <= ST_DONE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    half_sel   = 1'b0;
    active     = 1'b0;
    drive      = 1'b0;
    we_n       = 1'b1;
    oe_n       = 1'b0;
    wdata_half = lat_data[SRAM_DATA_W-1:0];
    case (state)
      ST_RD_LO: active = 1'b1;
      ST_RD_HI: begin
        active   = 1'b1;
        half_sel = 1'b1;
      end
      // WE_N rises for the final cycle of each half so data/address are stable at the strobe edge.
      ST_WR_LO: begin
        active = 1'b1;
        drive  = 1'b1;
        oe_n   = 1'b1;
        we_n   = last;
      end
      ST_WR_HI: begin
        active     = 1'b1;
        half_sel   = 1'b1;
        drive      = 1'b1;
        oe_n       = 1'b1;
        we_n       = last;
        wdata_half = lat_data[DATA_W-1:SRAM_DATA_W];
      end
      default: ;
    endcase
  end

  assign SRAM_ADDR = active ? {lat_addr, half_sel} : '0;
  assign SRAM_DQ   = drive ? wdata_half : 'z;
  assign SRAM_WE_N = we_n;
  assign SRAM_OE_N = oe_n;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

  // Ready while idle with nothing pending keeps the upstream cache from freezing.
  assign ready = ((state == ST_IDLE) && !rd_en && !wr_en) || (state == ST_DONE);

endmodule
